// File: rtl/lfsr_seq_checker.sv
// Receiving-end checker for a Fibonacci LFSR word stream: self-synchronises,
// then predicts each word, flags mispredictions and detects the all-zero lock-up word.
module lfsr_seq_checker #(
    parameter int         N        = 3,
    parameter logic [N:0] TAPS     = 4'b1101,
    parameter int         LOCK_CNT = 4,
    parameter int         LOSS_CNT = 3,
    parameter int         CW       = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [N:0]    q_in,
    input  logic          clr_cnt,
    output logic          locked,
    output logic          err_pulse,
    output logic [CW-1:0] err_count,
    output logic          stuck_zero
);

    localparam logic [0:0]    ST_HUNT   = 1'b0;
    localparam logic [0:0]    ST_LOCKED = 1'b1;
    localparam int            MW        = $clog2(LOCK_CNT + 1);
    localparam int            LW        = $clog2(LOSS_CNT + 1);
    localparam logic [MW-1:0] LOCK_V    = MW'(LOCK_CNT);
    localparam logic [LW-1:0] LOSS_V    = LW'(LOSS_CNT);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [N:0]    WORD_ZERO = {(N+1){1'b0}};

    logic [0:0]    state_q,     state_d;
    logic          have_ref_q,  have_ref_d;
    logic [N:0]    expected_q,  expected_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d;
    logic [LW-1:0] miss_cnt_q,  miss_cnt_d;
    logic          locked_q,    locked_d;
    logic          err_pulse_q, err_pulse_d;
    logic [CW-1:0] err_count_q, err_count_d;
    logic          stuck_q,     stuck_d;
    logic [CW-1:0] cnt_base_s;
    logic          zero_s;

    function automatic logic parity(input logic [N:0] w);
        return ^w;
    endfunction

    // Right shift with the tap parity fed back into the MSB.
    function automatic logic [N:0] nxt_word(input logic [N:0] w);
        return {parity(w & TAPS), w[N:1]};
    endfunction

    // Next-state logic: sync/lock state machine plus the clearable error counters.
    always_comb begin
        state_d     = state_q;
        have_ref_d  = have_ref_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        locked_d    = locked_q;
        err_pulse_d = 1'b0;
        zero_s      = in_valid && (q_in == WORD_ZERO);
        // The clear lands first so a coincident error or zero word still registers.
        cnt_base_s  = clr_cnt ? {CW{1'b0}} : err_count_q;
        err_count_d = cnt_base_s;
        stuck_d     = (clr_cnt ? 1'b0 : stuck_q) | zero_s;
        if (in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    expected_d = nxt_word(q_in);
                    have_ref_d = 1'b1;
                    if (have_ref_q && (q_in == expected_q) && !zero_s) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_d == LOCK_V) begin
                            state_d    = ST_LOCKED;
                            locked_d   = 1'b1;
                            miss_cnt_d = {LW{1'b0}};
                        end else begin
                            state_d    = ST_HUNT;
                            locked_d   = 1'b0;
                        end
                    end else begin
                        match_cnt_d = {MW{1'b0}};
                    end
                end
                ST_LOCKED: begin
                    // Freewheel so one corrupted word costs exactly one error.
                    expected_d = nxt_word(expected_q);
                    if (q_in == expected_q) begin
                        miss_cnt_d = {LW{1'b0}};
                    end else begin
                        err_pulse_d = 1'b1;
                        err_count_d = (cnt_base_s == CNT_MAX) ? CNT_MAX : cnt_base_s + 1'b1;
                        miss_cnt_d  = miss_cnt_q + 1'b1;
                        if (miss_cnt_d == LOSS_V) begin
                            state_d     = ST_HUNT;
                            locked_d    = 1'b0;
                            match_cnt_d = {MW{1'b0}};
                            have_ref_d  = 1'b1;
                            expected_d  = nxt_word(q_in);
                        end else begin
                            state_d     = ST_LOCKED;
                            locked_d    = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d     = ST_HUNT;
                    locked_d    = 1'b0;
                    have_ref_d  = 1'b0;
                    match_cnt_d = {MW{1'b0}};
                    miss_cnt_d  = {LW{1'b0}};
                end
            endcase
        end else begin
            err_pulse_d = 1'b0;
        end
    end

    // State and output registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            have_ref_q  <= 1'b0;
            expected_q  <= WORD_ZERO;
            match_cnt_q <= {MW{1'b0}};
            miss_cnt_q  <= {LW{1'b0}};
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= {CW{1'b0}};
            stuck_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            have_ref_q  <= have_ref_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            stuck_q     <= stuck_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign stuck_zero = stuck_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: stimulus pushes hand-derived expectations,
// a monitor pops and compares them one cycle after each sampled edge.
module tb_lfsr_seq_checker;

    typedef struct packed {
        logic        l;
        logic        p;
        logic [15:0] c;
        logic        s;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [3:0]  q_in;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic        stuck_zero;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks;
    int    n_fail;
    logic [3:0] seq [7];

    lfsr_seq_checker dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .q_in      (q_in),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .stuck_zero(stuck_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input exp_t e);
        n_checks++;
        if (locked !== e.l || err_pulse !== e.p || err_count !== e.c || stuck_zero !== e.s) begin
            n_fail++;
            $display("FAIL %s: got locked=%0b pulse=%0b cnt=%0d stuck=%0b, expected locked=%0b pulse=%0b cnt=%0d stuck=%0b",
                     name, locked, err_pulse, err_count, stuck_zero, e.l, e.p, e.c, e.s);
        end
    endtask

    task automatic step(input string name, input logic v, input logic [3:0] q, input logic clr,
                        input logic l, input logic p, input int c, input logic s);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        q_in     = q;
        clr_cnt  = clr;
        e.l = l;
        e.p = p;
        e.c = 16'(c);
        e.s = s;
        exp_q.push_back(e);
        tag_q.push_back(name);
    endtask

    // Monitor: compares outputs one cycle after each driven edge.
    initial begin
        exp_t  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, e);
            end
        end
    end

    initial begin
        exp_t zero_e;
        zero_e   = '0;
        n_checks = 0;
        n_fail   = 0;
        seq[0] = 4'h1; seq[1] = 4'h8; seq[2] = 4'hC; seq[3] = 4'h6;
        seq[4] = 4'hB; seq[5] = 4'h5; seq[6] = 4'h2;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        q_in     = 4'h0;
        clr_cnt  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", zero_e);
        reset_n = 1'b1;

        // Clean stream: lock one cycle after the 5th word, never an error.
        for (int i = 0; i < 50; i++)
            step("clean", 1'b1, seq[i % 7], 1'b0, (i >= 4), 1'b0, 0, 1'b0);

        // Single corrupted word C->D: exactly one error, lock kept.
        step("corr_pre", 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        step("corr_D",   1'b1, 4'hD, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        step("corr_6",   1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        step("corr_B",   1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        step("corr_5",   1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        step("corr_2",   1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        step("corr_1",   1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1, 1'b0);

        // Phase jump: three misses drop lock, four good words relock.
        step("jump_clr8", 1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step("jump_C",    1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        step("jump_m1",   1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        step("jump_m2",   1'b1, 4'h2, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        step("jump_m3",   1'b1, 4'h1, 1'b0, 1'b0, 1'b1, 3, 1'b0);
        step("relock_8",  1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        step("relock_C",  1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        step("relock_6",  1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 3, 1'b0);
        step("relock_B",  1'b1, 4'hB, 1'b0, 1'b1, 1'b0, 3, 1'b0);
        step("relock_5",  1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 3, 1'b0);
        step("relock_2",  1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 3, 1'b0);

        // Zero word, sticky flag, clears and clear-with-event ordering.
        step("zero_pre",  1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 3, 1'b0);
        step("zero_w",    1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 4, 1'b1);
        step("zero_C",    1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 4, 1'b1);
        step("zero_6",    1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 4, 1'b1);
        step("clr_B",     1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step("clr_err",   1'b1, 4'h7, 1'b1, 1'b1, 1'b1, 1, 1'b0);
        step("post_2",    1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        step("post_1",    1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        step("clr_zero",  1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1, 1'b1);
        step("post_C",    1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        step("gap_hold",  1'b0, 4'hF, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        step("post_6",    1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        step("clr_B2",    1'b1, 4'hB, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        // Alternate isolated misses and good words to build err_count=5 while locked.
        step("e_m1", 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1, 1'b0);
        step("e_g1", 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 1, 1'b0);
        step("e_m2", 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 2, 1'b0);
        step("e_g2", 1'b1, 4'h8, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        step("e_m3", 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 3, 1'b0);
        step("e_g3", 1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 3, 1'b0);
        step("e_m4", 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 4, 1'b0);
        step("e_g4", 1'b1, 4'h5, 1'b0, 1'b1, 1'b0, 4, 1'b0);
        step("e_m5", 1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 5, 1'b0);
        step("e_g5", 1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 5, 1'b0);

        // Asynchronous reset between edges while locked.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset", zero_e);
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b1;

        // Valid toggling 1/0: same lock point counted in valid samples.
        for (int i = 0; i < 10; i++) begin
            step("tog_v",   1'b1, seq[(3 + i) % 7], 1'b0, (i >= 4), 1'b0, 0, 1'b0);
            step("tog_gap", 1'b0, 4'h0, 1'b0, (i >= 4), 1'b0, 0, 1'b0);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
